// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the ALU decoder stage and alu_exec_unit.
// master drives the operation and flush; slave returns the result, zero flag and stall.
interface alu_exec_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3
);
    logic [CTRL_WIDTH-1:0] ALUControl;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  Valid;
    logic                  Flush;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;
    logic                  ResultValid;
    logic                  Stall;

    modport master (
        output ALUControl, SrcA, SrcB, Valid, Flush,
        input  ALUResult, Zero, ResultValid, Stall
    );

    modport slave (
        input  ALUControl, SrcA, SrcB, Valid, Flush,
        output ALUResult, Zero, ResultValid, Stall
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered ALU (add/sub/slt/mul/and/or); ALU_ITER_MUL_EN selects a DATA_WIDTH-cycle shift-add multiplier.
// Latency 1 (iterative mul DATA_WIDTH+1); Stall holds upstream while a mul is issuing or running, else never.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3
) (
    input  logic          CLK,
    input  logic          RST,
    alu_exec_unit_if.slave bus
);
    localparam logic [CTRL_WIDTH-1:0] OP_AND = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] OP_OR  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] OP_SUB = CTRL_WIDTH'(4);
    localparam logic [CTRL_WIDTH-1:0] OP_MUL = CTRL_WIDTH'(5);
    localparam logic [CTRL_WIDTH-1:0] OP_SLT = CTRL_WIDTH'(6);

    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_rv;
    logic [DATA_WIDTH-1:0] w_alu;
    logic                  w_issue;

    // Unlisted opcodes (including the add code itself) fall through to add.
    always_comb begin
        w_alu = bus.SrcA + bus.SrcB;
        case (bus.ALUControl)
            OP_AND:  w_alu = bus.SrcA & bus.SrcB;
            OP_OR:   w_alu = bus.SrcA | bus.SrcB;
            OP_SUB:  w_alu = bus.SrcA - bus.SrcB;
            OP_MUL:  w_alu = bus.SrcA * bus.SrcB;
            OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            default: w_alu = bus.SrcA + bus.SrcB;
        endcase
    end

    assign w_issue         = bus.Valid && !bus.Flush;
    assign bus.ALUResult   = r_result;
    assign bus.Zero        = r_zero;
    assign bus.ResultValid = r_rv;

`ifdef ALU_ITER_MUL_EN
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic                  w_mul_issue;

    assign w_mul_issue = w_issue && (bus.ALUControl == OP_MUL);
    assign w_acc_next  = r_b[0] ? (r_acc + r_a) : r_acc;
    assign bus.Stall   = (r_state == S_MUL) || w_mul_issue;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_rv     <= 1'b0;
            r_acc    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
        end else begin
            r_rv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mul_issue) begin
                        r_a     <= bus.SrcA;
                        r_b     <= bus.SrcB;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_MUL;
                    end else if (w_issue) begin
                        r_result <= w_alu;
                        r_zero   <= (w_alu == '0);
                        r_rv     <= 1'b1;
                    end
                end
                S_MUL: begin
                    // Valid is ignored here; only Flush can cut the operation short.
                    if (bus.Flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            r_state  <= S_IDLE;
                            r_result <= w_acc_next;
                            r_zero   <= (w_acc_next == '0);
                            r_rv     <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign bus.Stall = 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_rv     <= 1'b0;
        end else begin
            r_rv <= w_issue;
            if (w_issue) begin
                r_result <= w_alu;
                r_zero   <= (w_alu == '0);
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases plus randomized ops against a plain-arithmetic model.
module tb_alu_exec_unit;
    localparam int DW = 32;
`ifdef ALU_ITER_MUL_EN
    localparam bit ITER    = 1'b1;
    localparam int MUL_LAT = DW + 1;
`else
    localparam bit ITER    = 1'b0;
    localparam int MUL_LAT = 1;
`endif

    typedef struct {
        logic [DW-1:0] res;
        int            due;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    logic [DW-1:0] last_res = '0;

    alu_exec_unit_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(3)) bus ();

    alu_exec_unit #(.DATA_WIDTH(DW), .CTRL_WIDTH(3)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: each opcode from its arithmetic definition.
    function automatic logic [DW-1:0] model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] prod;
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b100: return a + (~b) + 1;
            3'b101: begin
                prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
                return prod[DW-1:0];
            end
            3'b110: begin
                if (a[DW-1] != b[DW-1]) return {{(DW-1){1'b0}}, a[DW-1]};
                else                    return {{(DW-1){1'b0}}, (a < b)};
            end
            default: return a + b;
        endcase
    endfunction

    always @(negedge CLK) begin
        if (bus.ResultValid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result_valid actual=%h required=no pulse (cycle %0d)", bus.ALUResult, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", bus.ALUResult, e.res);
                chk("zero", {31'b0, bus.Zero}, {31'b0, (e.res == '0)});
                chk("latency", cyc, e.due);
                last_res = e.res;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one op in the current cycle; for an iterative mul, walk through its busy cycles.
    task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit fl);
        bit is_mul;
        is_mul = (op == 3'b101);
        bus.ALUControl = op;
        bus.SrcA = a;
        bus.SrcB = b;
        bus.Valid = 1'b1;
        bus.Flush = fl;
        #1;
        chk("stall_at_issue", {31'b0, bus.Stall}, {31'b0, (ITER && is_mul && !fl)});
        if (!fl) sb.push_back('{res: model(op, a, b), due: cyc + (is_mul ? MUL_LAT : 1)});
        tick();
        bus.Valid = 1'b0;
        bus.Flush = 1'b0;
        if (ITER && is_mul && !fl) begin
            for (int k = 1; k < MUL_LAT; k++) begin
                chk("stall_busy", {31'b0, bus.Stall}, 32'd1);
                tick();
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        tick();
    endtask

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.ALUControl = '0;
        bus.SrcA = '0;
        bus.SrcB = '0;
        bus.Valid = 1'b0;
        bus.Flush = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("reset_result", bus.ALUResult, '0);
        chk("reset_zero", {31'b0, bus.Zero}, 32'd1);
        chk("reset_rv", {31'b0, bus.ResultValid}, 32'd0);
        chk("reset_stall", {31'b0, bus.Stall}, 32'd0);

        issue(3'b010, 32'd5, 32'd7, 1'b0);
        chk("add_stall_after", {31'b0, bus.Stall}, 32'd0);
        tick();
        issue(3'b100, 32'd7, 32'd7, 1'b0);
        issue(3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(3'b110, 32'd1, 32'hFFFF_FFFF, 1'b0);
        issue(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        issue(3'b001, 32'hF000_0000, 32'h0000_000F, 1'b0);
        issue(3'b011, 32'hFFFF_FFFF, 32'd2, 1'b0);
        issue(3'b111, 32'd40, 32'd2, 1'b0);
        issue(3'b101, 32'h0001_0003, 32'h10, 1'b0);
        issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drain();

        // Flush alongside Valid must suppress the issue and leave the result alone.
        issue(3'b010, 32'd100, 32'd200, 1'b1);
        issue(3'b101, 32'd3, 32'd4, 1'b1);
        repeat (3) tick();
        chk("flush_hold_result", bus.ALUResult, last_res);
        chk("flush_hold_zero", {31'b0, bus.Zero}, {31'b0, (last_res == '0)});

`ifdef ALU_ITER_MUL_EN
        issue(3'b001, 32'h1234_0000, 32'h0000_5678, 1'b0);
        drain();
        bus.ALUControl = 3'b101;
        bus.SrcA = 32'd9;
        bus.SrcB = 32'd9;
        bus.Valid = 1'b1;
        tick();
        bus.Valid = 1'b0;
        repeat (9) tick();
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        chk("mul_flush_stall", {31'b0, bus.Stall}, 32'd0);
        repeat (40) tick();
        chk("mul_flush_result", bus.ALUResult, last_res);

        bus.ALUControl = 3'b101;
        bus.SrcA = 32'd6;
        bus.SrcB = 32'd7;
        bus.Valid = 1'b1;
        tick();
        bus.Valid = 1'b0;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mul_rst_result", bus.ALUResult, '0);
        chk("mul_rst_zero", {31'b0, bus.Zero}, 32'd1);
        chk("mul_rst_stall", {31'b0, bus.Stall}, 32'd0);
        last_res = '0;
        repeat (40) tick();
`endif

        issue(3'b010, 32'd1, 32'd1, 1'b0);
        drain();

        for (int n = 0; n < 150; n++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 9) == 0));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
